// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-facing bundle of the branch target buffer.
// The master side drives lookups and resolved-branch updates. The slave side returns predictions.
interface branch_target_buffer_if #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 4
);
  localparam int OCC_W = $clog2(ENTRIES) + 1;

  logic              flush;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output flush, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_next_pc, occupancy
  );

  modport slave (
    input  flush, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_next_pc, occupancy
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational. Resolved-branch updates allocate or train entries on the next clock edge.
module branch_target_buffer #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

  typedef logic [IDX_W-1:0] idx_t;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_q, target_d;
  logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;
  idx_t                           rr_q, rr_d;
  logic [OCC_W-1:0]               occ_q, occ_d;

  logic [ENTRIES-1:0] lk_match, up_match;
  logic               lk_hit, lk_taken, up_hit, free_any;
  idx_t               lk_idx, up_idx, free_idx, victim;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign lk_match[g] = valid_q[g] && (tag_q[g] == bus.lookup_pc);
    assign up_match[g] = valid_q[g] && (tag_q[g] == bus.upd_pc);
  end

  // Descending scans so the lowest matching or free index ends up selected.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    up_hit   = 1'b0;
    up_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) begin
        lk_hit = 1'b1;
        lk_idx = idx_t'(i);
      end
      if (up_match[i]) begin
        up_hit = 1'b1;
        up_idx = idx_t'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

  assign lk_taken         = lk_hit && ctr_q[lk_idx][1];
  assign bus.pred_hit     = lk_hit;
  assign bus.pred_taken   = lk_taken;
  assign bus.pred_next_pc = lk_taken ? target_q[lk_idx] : bus.lookup_pc + PC_ONE;
  assign bus.occupancy    = occ_q;
  assign victim           = free_any ? free_idx : rr_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    rr_d     = rr_q;
    occ_d    = occ_q;
    if (bus.flush) begin
      valid_d = '0;
      rr_d    = '0;
      occ_d   = '0;
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          ctr_d[up_idx]    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
          target_d[up_idx] = bus.upd_target;
        end else begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[victim]  = 1'b1;
        tag_d[victim]    = bus.upd_pc;
        target_d[victim] = bus.upd_target;
        ctr_d[victim]    = 2'b10;
        if (free_any) occ_d = occ_q + OCC_ONE;
        else          rr_d  = rr_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rr_q    <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
    end
  end

  // Payload is meaningless while its valid bit is clear, so it carries no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, used in the fetch stage of `processor_project_pipeline`. It replaces the fixed four-entry jump lookup table. Fetch queries it combinationally with the current PC to obtain a next-PC prediction. The execute stage writes back resolved branch outcomes, which allocate or train entries on the following clock edge.

## Interface
- `ADDR_W`, 16: PC and target width (word addressed).
- `ENTRIES`, 4: number of fully-associative entries; power of two, ≥2.
- `clk` input, 1 bit: single clock, rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `flush` input, 1 bit: synchronous invalidate of all entries.
- `lookup_pc` input, ADDR_W bits: fetch-stage PC.
- `pred_hit` output, 1 bit: `lookup_pc` matches a valid entry.
- `pred_taken` output, 1 bit: hit and entry counter ≥ 2.
- `pred_next_pc` output, ADDR_W bits: predicted target if `pred_taken`, else `lookup_pc+1`.
- `upd_valid` input, 1 bit: resolved-branch update strobe from execute.
- `upd_pc` input, ADDR_W bits: PC of the resolved branch.
- `upd_taken` input, 1 bit: actual branch direction.
- `upd_target` input, ADDR_W bits: actual branch target.
- `occupancy` output, $clog2(ENTRIES)+1 bits: count of valid entries.

## Operation
- Each entry holds `valid`, `tag[ADDR_W]` (full PC), `target[ADDR_W]` and `ctr[1:0]`. There is also a round-robin pointer `rr[$clog2(ENTRIES)]`.
- **Lookup (combinational):**
  - A hit occurs when a valid entry has `tag == lookup_pc`. Update rules guarantee at most one match; if more than one matches, the lowest index wins.
  - `pred_next_pc` = `target` when `pred_taken`, otherwise `lookup_pc+1` modulo 2^ADDR_W, so 16'hFFFF yields 0.
- **Update hit** (`upd_valid` and `upd_pc` matches an entry):
  - Taken: `ctr` saturating increment, capped at 3, and `target <= upd_target`.
  - Not taken: `ctr` saturating decrement, floored at 0; target is unchanged.
  - Entries are never invalidated by training. A counter at 0 stays resident.
- **Update miss, taken:** allocate one entry with `valid=1`, `tag=upd_pc`, `target=upd_target`, `ctr=2'b10` (weakly taken).
  - Victim is the lowest-index invalid entry if one exists; `rr` is unchanged in that case.
  - If the table is full, the victim is entry `rr`, and `rr` increments modulo ENTRIES.
- **Update miss, not taken:** no state change.
- **Flush:** `flush` clears every `valid` bit and sets `rr=0`.
  - It has priority over a same-cycle update, which is discarded.
  - Tags, targets and counters are don't-care after a flush.
- **Reset:** same effect as flush, applied asynchronously.
  - After reset, `pred_hit=0`, `pred_taken=0`, `pred_next_pc=lookup_pc+1` and `occupancy=0`.
- **`occupancy`:** registered population count of `valid`. It increments only on allocation into an invalid slot and never exceeds ENTRIES.

## Timing
- Lookup has zero latency: outputs are pure functions of `lookup_pc` and the current registered state.
- Updates take effect at the rising edge where `upd_valid=1`. Their effect is visible on lookups from the next cycle.
- There is no bypass. A same-cycle lookup and update of the same PC returns the pre-update prediction.
- One update per cycle is accepted. There is no back-pressure and every strobe is consumed.
- Asserting `rst` mid-cycle immediately forces all outputs to their reset values, independent of `clk`.
- Deasserting `rst` allows updates from the next rising edge.

## Test plan
- **Reset:** `rst` pulse, then `lookup_pc=16'd16` -> `pred_hit=0`, `pred_taken=0`, `pred_next_pc=17`, `occupancy=0`.
- **Allocate and train:**
  - Update `upd_pc=16` taken, `upd_target=10`; next cycle lookup 16 -> hit, taken, next PC 10, occupancy 1.
  - Two not-taken updates for PC 16 -> counter 0; lookup -> hit, not taken, next PC 17.
  - Three taken updates -> counter 3; a fourth taken update leaves it saturated at 3.
- **Fill and round-robin replacement (ENTRIES=4):**
  - Taken updates for PCs 2, 5, 7 and 9 -> occupancy 4, `rr=0`.
  - Taken update for PC 12 evicts PC 2 -> lookup 2 misses, lookup 12 hits, `rr=1`.
  - Next allocation evicts PC 5.
- **Not-taken miss:** update PC 30 not taken on an empty table -> no allocation, occupancy stays 0.
- **Simultaneous events:**
  - Lookup 16 while updating PC 16 taken (first time) -> same-cycle `pred_hit=0`, next cycle hit.
  - `flush` and `upd_valid` in the same cycle -> all entries invalid, occupancy 0, update dropped.
- **Wrap and async reset:**
  - `lookup_pc=16'hFFFF` on a miss -> `pred_next_pc=0`.
  - Assert `rst` between clock edges with a full table -> `occupancy` drops to 0 immediately.
  - Repeat the tests with `ENTRIES=8` and `ADDR_W=12`.
